// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   - opcode-class codes carried in each ROB entry (LUI..RTYPE)
//   - TRUE/FALSE single-bit constants
//   - rob_id_w(): width of a ROB id for a given log2 depth
package rob_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [5:0] OPC_LUI    = 6'd0;
    localparam logic [5:0] OPC_AUIPC  = 6'd1;
    localparam logic [5:0] OPC_JAL    = 6'd2;
    localparam logic [5:0] OPC_JALR   = 6'd3;
    localparam logic [5:0] OPC_BRANCH = 6'd4;
    localparam logic [5:0] OPC_LOAD   = 6'd5;
    localparam logic [5:0] OPC_STORE  = 6'd6;
    localparam logic [5:0] OPC_OPIMM  = 6'd7;
    localparam logic [5:0] OPC_RTYPE  = 6'd8;
    localparam logic [5:0] OPC_OP     = OPC_RTYPE;

    function automatic int rob_id_w(input int depth_log);
        return (depth_log < 1) ? 1 : depth_log;
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Commit-slot qualification for the two oldest ROB entries.
// Ports:
//   rdy                   global enable; 0 forces all strobes low
//   has_one / has_two     at least one / two live entries
//   h0_* / h1_*           fields of the entries at head and head+1
//   reg_write[1:0]        per-slot register commit strobe
//   st_commit             store retire strobe (slot 0 only)
//   mispredict            branch at slot 0 retires with a wrong prediction
//   n_commit              number of entries retiring this cycle (0..2)
module rob_commit_sel
    import rob_pkg::*;
#(
    parameter int COMMIT_W = 2
) (
    input  logic       rdy,
    input  logic       has_one,
    input  logic       has_two,
    input  logic       h0_ready,
    input  logic [5:0] h0_opcode,
    input  logic       h0_pred_taken,
    input  logic       h0_value0,
    input  logic       h1_ready,
    input  logic [5:0] h1_opcode,
    output logic [1:0] reg_write,
    output logic       st_commit,
    output logic       mispredict,
    output logic [1:0] n_commit
);

    logic h0_special;
    logic h1_special;

    // Branches and stores have side effects outside the register file, so
    // they always retire alone in slot 0.
    assign h0_special = (h0_opcode == OPC_BRANCH) || (h0_opcode == OPC_STORE);
    assign h1_special = (h1_opcode == OPC_BRANCH) || (h1_opcode == OPC_STORE);

    always_comb begin
        reg_write  = '0;
        st_commit  = FALSE;
        mispredict = FALSE;
        n_commit   = 2'd0;
        if (rdy && has_one && h0_ready) begin
            n_commit = 2'd1;
            if (h0_opcode == OPC_STORE) begin
                st_commit = TRUE;
            end else if (h0_opcode == OPC_BRANCH) begin
                mispredict = (h0_pred_taken != h0_value0);
            end else begin
                reg_write[0] = TRUE;
            end
            if ((COMMIT_W == 2) && has_two && h1_ready && !h0_special && !h1_special) begin
                reg_write[1] = TRUE;
                n_commit     = 2'd2;
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: circular queue of 2**DEPTH_LOG in-flight instructions.
// One issue per cycle, CDB_N result buses, up to COMMIT_W in-order commits,
// self-flush and fetch redirect on a branch mispredict.
// Ports:
//   clk, rst, rdy                       clock, async active-high reset, global enable
//   is_*                                issue request, assigned id (tail) and full flag
//   q_id / q_rdy / q_val                two combinational operand lookups (CDB forwarded)
//   cdb_valid / cdb_id / cdb_value      result broadcast channels
//   cm_valid / cm_dest / cm_value / cm_rob_id   register commit slots
//   st_commit / st_lsb_id               store retire to the LSB
//   flush / flush_pc                    registered one-cycle redirect
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter int DEPTH_LOG = 4,
    parameter int CDB_N     = 2,
    parameter int COMMIT_W  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy,
    input  logic                            is_valid,
    output logic                            is_full,
    output logic [DEPTH_LOG-1:0]            is_rob_id,
    input  logic [5:0]                      is_opcode,
    input  logic                            is_ready,
    input  logic [31:0]                     is_value,
    input  logic [4:0]                      is_dest,
    input  logic                            is_pred_taken,
    input  logic [31:0]                     is_alt_pc,
    input  logic [2*DEPTH_LOG-1:0]          q_id,
    output logic [1:0]                      q_rdy,
    output logic [63:0]                     q_val,
    input  logic [CDB_N-1:0]                cdb_valid,
    input  logic [CDB_N*DEPTH_LOG-1:0]      cdb_id,
    input  logic [CDB_N*32-1:0]             cdb_value,
    output logic [COMMIT_W-1:0]             cm_valid,
    output logic [COMMIT_W*5-1:0]           cm_dest,
    output logic [COMMIT_W*32-1:0]          cm_value,
    output logic [COMMIT_W*DEPTH_LOG-1:0]   cm_rob_id,
    output logic                            st_commit,
    output logic [DEPTH_LOG-1:0]            st_lsb_id,
    output logic                            flush,
    output logic [31:0]                     flush_pc
);

    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam int CW    = DEPTH_LOG + 1;

    logic [DEPTH_LOG-1:0] head, tail, head_nxt1;
    logic [CW-1:0]        count;
    logic [DEPTH-1:0]     ready_q;
    logic [DEPTH-1:0]     pred_q;
    logic [31:0]          value_q  [DEPTH];
    logic [31:0]          alt_pc_q [DEPTH];
    logic [5:0]           opcode_q [DEPTH];
    logic [4:0]           dest_q   [DEPTH];

    logic                 issue_en;
    logic [CDB_N-1:0]     cdb_live;
    logic [1:0]           reg_write;
    logic [1:0]           n_commit;
    logic                 mispredict;
    logic [DEPTH_LOG-1:0] qid;
    logic [DEPTH_LOG-1:0] slot_id;

    assign is_full   = (count == CW'(DEPTH));
    assign is_rob_id = tail;
    assign issue_en  = rdy && is_valid && !is_full;
    assign head_nxt1 = head + DEPTH_LOG'(1);

    // An entry is live when its distance from head is below count.
    always_comb begin
        cdb_live = '0;
        for (int c = 0; c < CDB_N; c++) begin
            cdb_live[c] = cdb_valid[c] &&
                ({1'b0, cdb_id[c*DEPTH_LOG +: DEPTH_LOG] - head} < count);
        end
    end

    rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_commit_sel (
        .rdy           (rdy),
        .has_one       (count != '0),
        .has_two       (count > CW'(1)),
        .h0_ready      (ready_q[head]),
        .h0_opcode     (opcode_q[head]),
        .h0_pred_taken (pred_q[head]),
        .h0_value0     (value_q[head][0]),
        .h1_ready      (ready_q[head_nxt1]),
        .h1_opcode     (opcode_q[head_nxt1]),
        .reg_write     (reg_write),
        .st_commit     (st_commit),
        .mispredict    (mispredict),
        .n_commit      (n_commit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ready_q  <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                ready_q  <= '0;
                flush_pc <= alt_pc_q[head];
            end else if (rdy) begin
                head  <= head + DEPTH_LOG'(n_commit);
                count <= count + CW'(issue_en) - CW'(n_commit);
                if (issue_en) begin
                    tail          <= tail + DEPTH_LOG'(1);
                    ready_q[tail] <= is_ready;
                end
                for (int c = CDB_N - 1; c >= 0; c--) begin
                    if (cdb_live[c]) ready_q[cdb_id[c*DEPTH_LOG +: DEPTH_LOG]] <= 1'b1;
                end
            end
        end
    end

    // Entry payload is only meaningful while its ready/live state says so.
    // Descending channel loop makes the lowest channel the last writer.
    always_ff @(posedge clk) begin
        if (rdy && !mispredict) begin
            if (issue_en) begin
                value_q[tail]  <= is_value;
                alt_pc_q[tail] <= is_alt_pc;
                opcode_q[tail] <= is_opcode;
                dest_q[tail]   <= is_dest;
                pred_q[tail]   <= is_pred_taken;
            end
            for (int c = CDB_N - 1; c >= 0; c--) begin
                if (cdb_live[c]) begin
                    value_q[cdb_id[c*DEPTH_LOG +: DEPTH_LOG]] <= cdb_value[c*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        q_rdy = '0;
        q_val = '0;
        qid   = '0;
        for (int q = 0; q < 2; q++) begin
            qid = q_id[q*DEPTH_LOG +: DEPTH_LOG];
            if (ready_q[qid]) begin
                q_rdy[q]         = 1'b1;
                q_val[q*32 +: 32] = value_q[qid];
            end
            for (int c = CDB_N - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (cdb_id[c*DEPTH_LOG +: DEPTH_LOG] == qid)) begin
                    q_rdy[q]          = 1'b1;
                    q_val[q*32 +: 32] = cdb_value[c*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        cm_valid  = '0;
        cm_dest   = '0;
        cm_value  = '0;
        cm_rob_id = '0;
        slot_id   = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_id = head + DEPTH_LOG'(k);
            if (reg_write[k]) begin
                cm_valid[k]                      = 1'b1;
                cm_dest[k*5 +: 5]                = dest_q[slot_id];
                cm_value[k*32 +: 32]             = value_q[slot_id];
                cm_rob_id[k*DEPTH_LOG +: DEPTH_LOG] = slot_id;
            end
        end
    end

    assign st_lsb_id = st_commit ? dest_q[head][DEPTH_LOG-1:0] : '0;

endmodule
